// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared port numbering, sizing defaults and helpers for the
//               five-port NoC switch.
// Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 32;
    localparam int DEPTH     = 4;

    // Port index doubles as the destination code carried with each flit.
    typedef enum logic [2:0] {
        PORT_L = 3'd0,
        PORT_W = 3'd1,
        PORT_E = 3'd2,
        PORT_S = 3'd3,
        PORT_N = 3'd4
    } port_e;

    typedef logic [2:0] dest_t;

    // True when exactly one bit of a turn vector is set.
    function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
        return (v != '0) && ((v & (v - NUM_PORTS'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_fifo
// Description : Synchronous FIFO with asynchronous reset; head is read
//               straight from storage so a push is never bypassed to the
//               output in the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module noc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    import noc_pkg::*;

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/noc_switch.sv
`default_nettype none
// ============================================================================
// Module      : noc_switch
// Description : Five-port NoC switch: per-input FIFOs, arbiter-driven grant
//               decode, registered per-output flit stage and error pulse.
// Revision    : 1.0  initial release
// ============================================================================
module noc_switch #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [noc_pkg::NUM_PORTS-1:0]                 in_valid,
    output logic [noc_pkg::NUM_PORTS-1:0]                 in_ready,
    input  logic [noc_pkg::NUM_PORTS-1:0][FLIT_W-1:0]     in_data,
    input  logic [noc_pkg::NUM_PORTS-1:0][2:0]            in_dest,
    input  logic [noc_pkg::NUM_PORTS-1:0]                 N_turn_i,
    input  logic [noc_pkg::NUM_PORTS-1:0]                 S_turn_i,
    input  logic [noc_pkg::NUM_PORTS-1:0]                 E_turn_i,
    input  logic [noc_pkg::NUM_PORTS-1:0]                 W_turn_i,
    input  logic [noc_pkg::NUM_PORTS-1:0]                 L_turn_i,
    output logic [noc_pkg::NUM_PORTS-1:0]                 out_valid,
    input  logic [noc_pkg::NUM_PORTS-1:0]                 out_ready,
    output logic [noc_pkg::NUM_PORTS-1:0][FLIT_W-1:0]     out_data,
    output logic                                          err_o
);
    import noc_pkg::*;

    logic [NUM_PORTS-1:0]                 w_full;
    logic [NUM_PORTS-1:0]                 w_empty;
    logic [NUM_PORTS-1:0]                 w_push;
    logic [NUM_PORTS-1:0]                 w_pop;
    logic [NUM_PORTS-1:0]                 w_drop;
    logic [NUM_PORTS-1:0]                 w_onehot;
    logic [NUM_PORTS-1:0]                 w_multi;
    logic [NUM_PORTS-1:0]                 w_free;
    logic [NUM_PORTS-1:0]                 w_load;
    logic [NUM_PORTS-1:0][FLIT_W+2:0]     w_fifo_q;
    logic [NUM_PORTS-1:0][FLIT_W-1:0]     w_head_data;
    logic [NUM_PORTS-1:0][2:0]            w_head_dest;
    logic [NUM_PORTS-1:0][FLIT_W-1:0]     w_load_data;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  w_turn;
    logic [NUM_PORTS-1:0]                 r_out_valid;
    logic [NUM_PORTS-1:0][FLIT_W-1:0]     r_out_data;
    logic                                 r_err;

    // Turn vectors indexed by output port.
    assign w_turn[PORT_L] = L_turn_i;
    assign w_turn[PORT_W] = W_turn_i;
    assign w_turn[PORT_E] = E_turn_i;
    assign w_turn[PORT_S] = S_turn_i;
    assign w_turn[PORT_N] = N_turn_i;

    // Acceptance depends only on FIFO state, never on in_valid.
    assign in_ready  = rst ? '0 : ~w_full;
    assign w_push    = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err_o     = r_err;

    generate
        for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
            noc_fifo #(
                .WIDTH (FLIT_W + 3),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[k]),
                .i_data  ({in_dest[k], in_data[k]}),
                .i_pop   (w_pop[k]),
                .o_data  (w_fifo_q[k]),
                .o_full  (w_full[k]),
                .o_empty (w_empty[k])
            );
            assign w_head_dest[k] = w_fifo_q[k][FLIT_W +: 3];
            assign w_head_data[k] = w_fifo_q[k][FLIT_W-1:0];
            assign w_onehot[k]    = is_onehot(w_turn[k]);
            assign w_multi[k]     = (w_turn[k] != '0) && !w_onehot[k];
            assign w_free[k]      = !r_out_valid[k] || out_ready[k];
        end
    endgenerate

    // Grant decode: drop malformed heads, otherwise move a head to its
    // output when that output grants this input alone and has room.
    always_comb begin
        w_pop       = '0;
        w_drop      = '0;
        w_load      = '0;
        w_load_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_empty[k]) begin
                if (w_head_dest[k] > dest_t'(PORT_N) || w_head_dest[k] == dest_t'(k)) begin
                    w_pop[k]  = 1'b1;
                    w_drop[k] = 1'b1;
                end else begin
                    for (int d = 0; d < NUM_PORTS; d++) begin
                        if (w_head_dest[k] == dest_t'(d) && w_turn[d][k] &&
                            w_onehot[d] && w_free[d]) begin
                            w_pop[k]       = 1'b1;
                            w_load[d]      = 1'b1;
                            w_load_data[d] = w_head_data[k];
                        end
                    end
                end
            end
        end
    end

    // Output stage: load on transfer, hold while stalled, clear when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            for (int d = 0; d < NUM_PORTS; d++) begin
                if (w_load[d]) begin
                    r_out_valid[d] <= 1'b1;
                    r_out_data[d]  <= w_load_data[d];
                end else if (out_ready[d]) begin
                    r_out_valid[d] <= 1'b0;
                end
            end
            r_err <= (|w_drop) || (|w_multi);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_switch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_noc_switch
// Description : Directed scoreboard bench for noc_switch.
// Revision    : 1.0  initial release
// ============================================================================
module tb_noc_switch;

    typedef struct {
        int          dst;
        logic [31:0] data;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [4:0]      in_valid;
    logic [4:0]      in_ready;
    logic [4:0][31:0] in_data;
    logic [4:0][2:0] in_dest;
    logic [4:0]      turn_n;
    logic [4:0]      turn_s;
    logic [4:0]      turn_e;
    logic [4:0]      turn_w;
    logic [4:0]      turn_l;
    logic [4:0]      out_valid;
    logic [4:0]      out_ready;
    logic [4:0][31:0] out_data;
    logic            err_o;

    int   tests    = 0;
    int   fails    = 0;
    int   err_seen = 0;
    int   exp_err  = 0;
    exp_t sb[$];

    noc_switch #(.FLIT_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .N_turn_i  (turn_n),
        .S_turn_i  (turn_s),
        .E_turn_i  (turn_e),
        .W_turn_i  (turn_w),
        .L_turn_i  (turn_l),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Present one flit on input k (called at a negedge) and wait for acceptance.
    task automatic send(input int k, input logic [31:0] d, input logic [2:0] dst, input bit expect_out);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_dest[k]  = dst;
        if (expect_out) sb.push_back('{int'(dst), d});
        if (dst > 3'd4 || int'(dst) == k) exp_err++;
        while (!in_ready[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(n < 40), 32'd1);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    // Monitor: samples between edges, pops scoreboard on every handshake,
    // checks stalled outputs hold, tallies error pulses.
    initial begin : monitor
        logic [4:0]       hold;
        logic [4:0][31:0] hold_d;
        int               idx;
        hold = '0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold = '0;
            end else begin
                if (err_o) err_seen++;
                for (int d = 0; d < 5; d++) begin
                    if (hold[d]) begin
                        check("hold_valid", 32'(out_valid[d]), 32'd1);
                        check("hold_data", out_data[d], hold_d[d]);
                    end
                    hold[d]   = out_valid[d] && !out_ready[d];
                    hold_d[d] = out_data[d];
                    if (out_valid[d] && out_ready[d]) begin
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++)
                            if (idx < 0 && sb[i].dst == d) idx = i;
                        tests++;
                        if (idx < 0) begin
                            fails++;
                            $display("FAIL unexpected_out port %0d: got 0x%0h, required no flit", d, out_data[d]);
                        end else begin
                            if (out_data[d] !== sb[idx].data) begin
                                fails++;
                                $display("FAIL out_data port %0d: got 0x%0h, required 0x%0h", d, out_data[d], sb[idx].data);
                            end
                            sb.delete(idx);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        in_dest = '0;
        out_ready = 5'h1F;
        turn_n = '0; turn_s = '0; turn_e = '0; turn_w = '0; turn_l = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_out_data", 32'(|out_data), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1F);
        @(negedge clk);

        // S -> N, minimum latency
        turn_n = 5'b01000;
        in_valid[3] = 1'b1; in_data[3] = 32'hA5A5A5A5; in_dest[3] = 3'd4;
        sb.push_back('{4, 32'hA5A5A5A5});
        check("lat_in_ready", 32'(in_ready[3]), 32'd1);
        @(negedge clk);
        in_valid[3] = 1'b0;
        check("lat_cycle1_valid", 32'(out_valid[4]), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid[4]), 32'd1);
        check("lat_cycle2_data", out_data[4], 32'hA5A5A5A5);
        check("lat_err", 32'(err_o), 32'd0);
        turn_n = '0;
        repeat (3) @(negedge clk);

        // E -> W: fill FIFO with no grant, then drain in order
        for (int i = 1; i <= 4; i++) send(2, 32'(i), 3'd1, 1'b1);
        check("full_in_ready", 32'(in_ready[2]), 32'd0);
        check("full_no_out", 32'(out_valid[1]), 32'd0);
        turn_w = 5'b00100;
        send(2, 32'd5, 3'd1, 1'b1);
        repeat (8) @(negedge clk);
        turn_w = '0;

        // N -> L with downstream stall
        out_ready[0] = 1'b0;
        turn_l = 5'b10000;
        send(4, 32'h11, 3'd0, 1'b1);
        send(4, 32'h22, 3'd0, 1'b1);
        check("stall_valid", 32'(out_valid[0]), 32'd1);
        check("stall_data", out_data[0], 32'h11);
        repeat (3) @(negedge clk);
        check("stall_data_held", out_data[0], 32'h11);
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("release_next_valid", 32'(out_valid[0]), 32'd1);
        check("release_next_data", out_data[0], 32'h22);
        repeat (3) @(negedge clk);
        turn_l = '0;

        // L U-turn and illegal destination code
        send(0, 32'h0BAD0000, 3'd0, 1'b0);
        send(0, 32'h0BAD0006, 3'd6, 1'b0);
        repeat (4) @(negedge clk);
        check("drop_err_count", 32'(err_seen), 32'(exp_err));
        check("drop_err_idle", 32'(err_o), 32'd0);

        // W and L both to E: malformed grant, then L only, then W
        send(1, 32'h000E0001, 3'd2, 1'b0);
        send(0, 32'h000E0000, 3'd2, 1'b1);
        turn_e = 5'b00011;
        exp_err++;
        @(negedge clk);
        check("multi_err", 32'(err_o), 32'd1);
        check("multi_no_xfer", 32'(out_valid[2]), 32'd0);
        turn_e = 5'b00001;
        @(negedge clk);
        check("grant_l_valid", 32'(out_valid[2]), 32'd1);
        check("grant_l_data", out_data[2], 32'h000E0000);
        check("grant_l_err", 32'(err_o), 32'd0);
        sb.push_back('{2, 32'h000E0001});
        turn_e = 5'b00010;
        repeat (3) @(negedge clk);
        turn_e = '0;
        check("multi_err_count", 32'(err_seen), 32'(exp_err));

        // Reset with flits buffered and an output occupied
        out_ready[3] = 1'b0;
        turn_s = 5'b10000;
        for (int i = 0; i < 4; i++) send(4, 32'hC0 + 32'(i), 3'd3, 1'b0);
        check("pre_rst_valid", 32'(out_valid[3]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 5'h1F;
        rst = 1'b0;
        #1;
        check("rel_rst_in_ready", 32'(in_ready), 32'h1F);
        repeat (6) @(negedge clk);
        check("no_stale_out", 32'(out_valid), 32'd0);
        turn_s = '0;

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("final_err_count", 32'(err_seen), 32'(exp_err));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_switch.md
NOC_SWITCH -- requirements
Module: noc_switch

Interface
REQ-001 Parameter FLIT_W, default 32, flit payload width.
REQ-002 Parameter DEPTH, default 4, per-input FIFO entries; SHALL be a power of two, >=2.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  5  per-input flit valid; port index 4=N, 3=S, 2=E, 1=W, 0=L.
REQ-006 in_ready  output  5  per-input accept.
REQ-007 in_data  input  5xFLIT_W  per-input flit payload.
REQ-008 in_dest  input  5x3  per-input destination code (0=L, 1=W, 2=E, 3=S, 4=N).
REQ-009 N_turn_i, S_turn_i, E_turn_i, W_turn_i, L_turn_i  input  5 each  registered one-hot grant from the arbiter; bit k set = input k may send to that output.
REQ-010 out_valid  output  5  per-output flit valid, same index order.
REQ-011 out_ready  input  5  downstream accept per output.
REQ-012 out_data  output  5xFLIT_W  per-output flit.
REQ-013 err_o  output  1  one-cycle pulse on discarded flit or malformed turn vector.

Function
REQ-014 Input push: transfer when in_valid[k] & in_ready[k]; in_ready[k] = FIFO k not full; no combinational path from in_valid to in_ready.
REQ-015 Push into empty FIFO SHALL NOT bypass; head becomes visible the following cycle.
REQ-016 Full FIFO: in_ready=0, even if a pop occurs the same cycle.
REQ-017 Simultaneous push and pop on a non-full FIFO: both occur; occupancy unchanged.
REQ-018 Output register d is "free" when out_valid[d]=0 or out_ready[d]=1.
REQ-019 Transfer: head of FIFO k with dest d moves to output register d when FIFO k non-empty, turn vector of d has bit k set, turn vector of d one-hot, output d free.
REQ-020 At most one transfer per output per cycle; each input pops at most one flit per cycle.
REQ-021 Minimum latency: flit accepted at edge t, popped at edge t+1, out_valid at t+1 after edge; i.e. visible 2 cycles after in_valid presented.
REQ-022 While out_valid[d]=1 and out_ready[d]=0, out_data[d] SHALL be held stable.
REQ-023 out_valid[d] clears on out_ready[d] with no new transfer into d.
REQ-024 U-turn (dest == own index) or dest code 5-7: head popped without forwarding, err_o pulsed next cycle.
REQ-025 Turn vector with more than one bit set: no transfer to that output that cycle, err_o pulsed.
REQ-026 Turn vector all zero: output idle, no error.
REQ-027 Flit order per input-output pair SHALL be preserved.
REQ-028 Head blocked (grant absent or output busy) SHALL block only its own input FIFO.

Reset
REQ-029 While rst=1: all FIFOs empty, pointers 0, out_valid=0, out_data=0, err_o=0, in_ready=0.
REQ-030 First cycle after rst deasserts: in_ready=5'b11111.
REQ-031 Reset mid-transfer SHALL discard all buffered and registered flits without further out_valid.

Structure
REQ-032 Shared package noc_pkg: port index constants/enum (L,W,E,S,N), NUM_PORTS=5, FLIT_W, DEPTH, dest code type.
REQ-033 Single sub-module noc_fifo (synchronous FIFO, async reset, full/empty, DEPTH entries), instantiated five times.
REQ-034 Output registers and grant decode reside in noc_switch.

Verification
REQ-035 S input sends 0xA5A5A5A5 dest N, N_turn_i=5'b01000 held, out_ready[4]=1 -> out_valid[4] two cycles after presentation, out_data[4]=0xA5A5A5A5, err_o=0.
REQ-036 Input E pushes 5 flits 1..5 dest W, W_turn_i=0 -> in_ready[2]=0 after 4 accepted; then W_turn_i=5'b00100 -> out_data[1] yields 1,2,3,4 in order, then 5 accepted and delivered.
REQ-037 out_ready[0]=0 for 3 cycles with out_valid[0]=1 -> out_data[0] unchanged; release -> next flit follows one cycle later.
REQ-038 Input L sends dest code 0 (U-turn), then dest code 6 -> both flits dropped, err_o pulses twice, no out_valid.
REQ-039 E_turn_i=5'b00011 with flits pending from W and L dest E -> no transfer, err_o=1; E_turn_i=5'b00001 -> L flit forwarded only.
REQ-040 rst asserted with 3 flits buffered and out_valid[3]=1 -> out_valid=0, in_ready=0 immediately; after release in_ready=5'b11111, no stale output.
